// File: rtl/serial_key_decoder_if.sv
// Bus bundle for serial_key_decoder: serial frame input, control and status outputs.
// Optional feature macro of the decoder: KEY_DECODER_TIMEOUT_EN (no effect on this bundle).
interface serial_key_decoder_if #(
  parameter int MODE_W   = 1,
  parameter int MAX_FAIL = 3
);
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);

  // Handshake: ValidCmd=1 qualifies InputKey for exactly the cycle it is high; there is
  // no ready/backpressure, the decoder consumes (or deliberately ignores) every valid bit.
  logic              ValidCmd;
  logic              InputKey;
  logic              Clear;
  logic              Active;
  logic [MODE_W-1:0] Mode;
  logic              KeyError;
  logic              Locked;
  logic [FAIL_W-1:0] FailCount;
  // FSM state for observation: 0=COLLECT, 1=ACTIVE, 2=LOCKED
  logic [1:0]        StateDbg;

  modport master (
    output ValidCmd, InputKey, Clear,
    input  Active, Mode, KeyError, Locked, FailCount, StateDbg
  );

  modport slave (
    input  ValidCmd, InputKey, Clear,
    output Active, Mode, KeyError, Locked, FailCount, StateDbg
  );
endinterface

// File: rtl/serial_key_decoder.sv
// Serial key decoder: collects MODE_W mode bits then KEY_W key bits (MSB first),
// compares the key with SECRET, counts consecutive failures and locks out after MAX_FAIL.
// Optional feature macro: KEY_DECODER_TIMEOUT_EN (discard a partial frame after
// TIMEOUT_CYCLES consecutive idle cycles).
module serial_key_decoder #(
  parameter int               KEY_W          = 4,
  parameter logic [KEY_W-1:0] SECRET         = 4'b0101,
  parameter int               MODE_W         = 1,
  parameter int               MAX_FAIL       = 3,
  parameter int               LOCK_CYCLES    = 16,
  parameter int               TIMEOUT_CYCLES = 8
) (
  input logic                 Clk,
  input logic                 Reset,
  serial_key_decoder_if.slave bus
);
  localparam int FRAME_W = MODE_W + KEY_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int FAIL_W  = $clog2(MAX_FAIL + 1);
  localparam int LOCK_W  = $clog2(LOCK_CYCLES + 1);
  localparam int IDLE_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(FRAME_W - 1);
  localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_FAIL);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

`ifdef KEY_DECODER_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    ACTIVE  = 2'd1,
    LOCKED  = 2'd2
  } stateT;

  stateT state, stateNxt;

  logic [FRAME_W-2:0] shiftReg, shiftNxt;
  logic [CNT_W-1:0]   bitCnt, bitCntNxt;
  logic [FAIL_W-1:0]  failCnt, failNxt;
  logic [LOCK_W-1:0]  lockCnt, lockNxt;
  logic [IDLE_W-1:0]  idleCnt, idleNxt;
  logic               activeQ, activeNxt;
  logic [MODE_W-1:0]  modeQ, modeNxt;
  logic               keyErrQ, keyErrNxt;
  logic               lockedQ, lockedNxt;

  // Frame assembled as if the current bit were already shifted in
  logic [FRAME_W-1:0] frame;
  logic               frameDone;
  logic               keyMatch;
  logic [FAIL_W-1:0]  failInc;

  assign frame     = {shiftReg, bus.InputKey};
  assign frameDone = bus.ValidCmd && !bus.Clear && (bitCnt == CNT_LAST);
  assign keyMatch  = (frame[KEY_W-1:0] == SECRET);
  assign failInc   = (failCnt == FAIL_MAX) ? failCnt : failCnt + 1'b1;

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state <= COLLECT;
    else       state <= stateNxt;
  end

  // Next-state decode
  always_comb begin
    stateNxt = state;
    case (state)
      COLLECT: begin
        if (state == COLLECT && frameDone) begin
          if (keyMatch)                 stateNxt = ACTIVE;
          else if (failInc == FAIL_MAX) stateNxt = LOCKED;
        end
      end
      ACTIVE:  if (bus.Clear) stateNxt = COLLECT;
      LOCKED:  if (lockCnt == LOCK_LAST) stateNxt = COLLECT;
      default: stateNxt = COLLECT;
    endcase
  end

  // Next values for the datapath and the registered outputs
  always_comb begin
    shiftNxt  = shiftReg;
    bitCntNxt = bitCnt;
    failNxt   = failCnt;
    lockNxt   = lockCnt;
    idleNxt   = idleCnt;
    activeNxt = activeQ;
    modeNxt   = modeQ;
    keyErrNxt = 1'b0;
    lockedNxt = lockedQ;
    case (state)
      COLLECT: begin
        if (bus.Clear) begin
          bitCntNxt = '0;
          idleNxt   = '0;
        end else if (bus.ValidCmd) begin
          idleNxt = '0;
          if (frameDone) begin
            bitCntNxt = '0;
            shiftNxt  = '0;
            if (keyMatch) begin
              activeNxt = 1'b1;
              modeNxt   = frame[FRAME_W-1:KEY_W];
              failNxt   = '0;
            end else begin
              keyErrNxt = 1'b1;
              failNxt   = failInc;
              if (failInc == FAIL_MAX) begin
                lockedNxt = 1'b1;
                lockNxt   = '0;
              end
            end
          end else begin
            shiftNxt  = frame[FRAME_W-2:0];
            bitCntNxt = bitCnt + 1'b1;
          end
        end else if (TIMEOUT_EN && bitCnt != '0) begin
          if (idleCnt == IDLE_LAST) begin
            bitCntNxt = '0;
            idleNxt   = '0;
          end else begin
            idleNxt = idleCnt + 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (bus.Clear) begin
          activeNxt = 1'b0;
          modeNxt   = '0;
        end
      end
      LOCKED: begin
        if (lockCnt == LOCK_LAST) begin
          lockedNxt = 1'b0;
          failNxt   = '0;
          bitCntNxt = '0;
          lockNxt   = '0;
        end else begin
          lockNxt = lockCnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      shiftReg <= '0;
      bitCnt   <= '0;
      failCnt  <= '0;
      lockCnt  <= '0;
      idleCnt  <= '0;
      activeQ  <= 1'b0;
      modeQ    <= '0;
      keyErrQ  <= 1'b0;
      lockedQ  <= 1'b0;
    end else begin
      shiftReg <= shiftNxt;
      bitCnt   <= bitCntNxt;
      failCnt  <= failNxt;
      lockCnt  <= lockNxt;
      idleCnt  <= idleNxt;
      activeQ  <= activeNxt;
      modeQ    <= modeNxt;
      keyErrQ  <= keyErrNxt;
      lockedQ  <= lockedNxt;
    end
  end

  assign bus.Active    = activeQ;
  assign bus.Mode      = modeQ;
  assign bus.KeyError  = keyErrQ;
  assign bus.Locked    = lockedQ;
  assign bus.FailCount = failCnt;
  assign bus.StateDbg  = state;
endmodule

// File: tb/tb_serial_key_decoder.sv
// Bench for serial_key_decoder: directed scenarios plus random traffic, every cycle
// checked against a queue-based reference model of the frame rules.
module tb_serial_key_decoder;
  localparam int KEY_W          = 4;
  localparam int MODE_W         = 1;
  localparam int FRAME_W        = KEY_W + MODE_W;
  localparam int SECRET         = 5;
  localparam int MAX_FAIL       = 3;
  localparam int LOCK_CYCLES    = 16;
  localparam int TIMEOUT_CYCLES = 8;
`ifdef KEY_DECODER_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  // Clock and reset
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  serial_key_decoder_if #(.MODE_W(MODE_W), .MAX_FAIL(MAX_FAIL)) bus ();

  serial_key_decoder #(
    .KEY_W(KEY_W), .SECRET(4'b0101), .MODE_W(MODE_W), .MAX_FAIL(MAX_FAIL),
    .LOCK_CYCLES(LOCK_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .bus(bus.slave)
  );

  int vectors = 0;
  int miscompares = 0;

  // Scoreboard: mode values expected at each Active rising edge
  logic [MODE_W-1:0] expQ[$];

  // Reference model state
  int   bitQ[$];
  logic mActive;
  int   mMode;
  int   mFail;
  int   mLockLeft;
  int   mIdle;
  logic mKeyErr;
  logic prevActive = 1'b0;
  logic sawKeyErr;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void modelStep(input logic v, input logic k, input logic c, input logic r);
    mKeyErr = 1'b0;
    if (r) begin
      bitQ.delete();
      mActive = 0; mMode = 0; mFail = 0; mLockLeft = 0; mIdle = 0;
    end else if (mLockLeft > 0) begin
      mLockLeft--;
      if (mLockLeft == 0) begin
        mFail = 0;
        bitQ.delete();
      end
    end else if (mActive) begin
      if (c) begin
        mActive = 0;
        mMode = 0;
      end
    end else if (c) begin
      bitQ.delete();
      mIdle = 0;
    end else if (v) begin
      mIdle = 0;
      bitQ.push_back(int'(k));
      if (bitQ.size() == FRAME_W) begin
        int val = 0;
        foreach (bitQ[i]) val = val * 2 + bitQ[i];
        bitQ.delete();
        if (val % (1 << KEY_W) == SECRET) begin
          mActive = 1;
          mMode = val >> KEY_W;
          mFail = 0;
          expQ.push_back(MODE_W'(mMode));
        end else begin
          mKeyErr = 1'b1;
          if (mFail < MAX_FAIL) mFail++;
          if (mFail == MAX_FAIL) mLockLeft = LOCK_CYCLES;
        end
      end
    end else if (TIMEOUT_ON && bitQ.size() > 0) begin
      mIdle++;
      if (mIdle == TIMEOUT_CYCLES) begin
        bitQ.delete();
        mIdle = 0;
      end
    end
  endfunction

  // Driver: apply one cycle of inputs, advance the model, check all outputs after the edge
  task automatic cycle(input logic v, input logic k, input logic c, input logic r);
    bus.ValidCmd = v;
    bus.InputKey = k;
    bus.Clear    = c;
    Reset        = r;
    @(posedge Clk);
    modelStep(v, k, c, r);
    #1;
    checkVal("active", 32'(bus.Active), 32'(mActive));
    checkVal("mode", 32'(bus.Mode), mActive ? mMode : 0);
    checkVal("key_error", 32'(bus.KeyError), 32'(mKeyErr));
    checkVal("locked", 32'(bus.Locked), 32'(mLockLeft > 0));
    checkVal("fail_count", 32'(bus.FailCount), mFail);
    if (bus.KeyError) sawKeyErr = 1'b1;
    if (bus.Active && !prevActive) begin
      checkVal("active_rise_expected", expQ.size(), 1);
      if (expQ.size() > 0) checkVal("mode_at_rise", 32'(bus.Mode), 32'(expQ.pop_front()));
    end
    prevActive = bus.Active;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic sendFrame(input logic [FRAME_W-1:0] f, input int gap);
    for (int i = FRAME_W - 1; i >= 0; i--) begin
      cycle(1'b1, f[i], 1'b0, 1'b0);
      idle(gap);
    end
  endtask

  initial begin
    bus.ValidCmd = 1'b0;
    bus.InputKey = 1'b0;
    bus.Clear    = 1'b0;
    sawKeyErr    = 1'b0;
    mActive = 0; mMode = 0; mFail = 0; mLockLeft = 0; mIdle = 0; mKeyErr = 0;

    // Reset state
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    checkVal("reset_state", 32'(bus.StateDbg), 0);

    // 1: back-to-back good frame with mode 1, then Clear
    sendFrame(5'b10101, 0);
    checkVal("t1_active", 32'(bus.Active), 1);
    checkVal("t1_mode", 32'(bus.Mode), 1);
    idle(3);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    checkVal("t1_clear_active", 32'(bus.Active), 0);

    // 2: gapped good frame with mode 0, extra bits while active
    sendFrame(5'b00101, 2);
    checkVal("t2_active", 32'(bus.Active), 1);
    sendFrame(5'b11111, 0);
    checkVal("t2_still_active", 32'(bus.Active), 1);
    checkVal("t2_no_error", 32'(sawKeyErr), 0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);

    // 3: three bad frames -> lockout; good frame during lockout ignored
    sendFrame(5'b11111, 0);
    sendFrame(5'b11111, 0);
    sendFrame(5'b11111, 0);
    checkVal("t3_locked", 32'(bus.Locked), 1);
    checkVal("t3_fail3", 32'(bus.FailCount), 3);
    sendFrame(5'b10101, 0);
    idle(LOCK_CYCLES - FRAME_W + 1);
    checkVal("t3_unlocked", 32'(bus.Locked), 0);
    sendFrame(5'b10101, 0);
    checkVal("t3_active_after", 32'(bus.Active), 1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);

    // 4: two bad then a good frame
    sendFrame(5'b00000, 1);
    sendFrame(5'b01111, 0);
    checkVal("t4_fail2", 32'(bus.FailCount), 2);
    sendFrame(5'b00101, 0);
    checkVal("t4_fail0", 32'(bus.FailCount), 0);
    checkVal("t4_active", 32'(bus.Active), 1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);

    // 5: reset mid-frame, then Clear colliding with a valid bit
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    sendFrame(5'b10101, 0);
    checkVal("t5_active_after_reset", 32'(bus.Active), 1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    sendFrame(5'b10101, 0);
    checkVal("t5_active_after_clear", 32'(bus.Active), 1);

    // 6: two bits, 8 idle cycles, then a good frame
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    sawKeyErr = 1'b0;
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    idle(TIMEOUT_CYCLES);
    sendFrame(5'b10101, 0);
    idle(2);
    checkVal("t6_key_error_seen", 32'(sawKeyErr), TIMEOUT_ON ? 0 : 1);

    // Random traffic, with occasional well-formed good frames
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        sendFrame(FRAME_W'({$urandom_range(0, 1), 4'b0101}), $urandom_range(0, 1));
      end else begin
        cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 19) == 0, $urandom_range(0, 199) == 0);
      end
    end
    checkVal("scoreboard_drained", expQ.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
